// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite slave I2S transmitter: 32-bit TX FIFO feeding a Philips-format
// I2S master (SCK/WS/SD), left slot first, with a level-threshold interrupt.
module ahbl_i2s_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HSEL,
  input  logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             SCK,
  output logic             WS,
  output logic             SD,
  output logic             IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]       addr_r;
  logic             write_r;
  logic             trans_r;
  logic             sel_r;

  logic             ctrl_en_r;
  logic             irq_en_r;
  logic             flush_r;
  logic [DIV_W-1:0] presc_r;
  logic [LW-1:0]    thresh_r;
  logic             unf_r;
  logic             ovf_r;
  logic             irq_r;

  logic [31:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;

  logic [DIV_W-1:0] presc_cnt_r;
  logic [DIV_W-1:0] presc_act_r;
  logic             sck_r;
  logic             ws_r;
  logic             sd_r;
  logic [5:0]       bit_cnt_r;
  logic [31:0]      shift_r;
  logic             started_r;

  logic             wr_s;
  logic             ctrl_wr_s;
  logic             data_wr_s;
  logic             stat_wr_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             eng_off_s;
  logic             tick_s;
  logic             fall_s;
  logic [5:0]       bit_next_s;
  logic             k0_s;
  logic             k1_s;
  logic [31:0]      fifo_head_s;
  logic             unused_s;

  assign wr_s      = trans_r & sel_r & write_r;
  assign ctrl_wr_s = wr_s & (addr_r == 8'h00);
  assign data_wr_s = wr_s & (addr_r == 8'h04);
  assign stat_wr_s = wr_s & (addr_r == 8'h08);

  assign empty_s     = (level_r == {LW{1'b0}});
  assign full_s      = (level_r == LW'(FIFO_DEPTH));
  assign fifo_head_s = empty_s ? 32'd0 : mem_r[rd_ptr_r];

  // A write clearing EN stops the engine at the same edge it lands in CTRL
  assign eng_off_s  = ~ctrl_en_r | (ctrl_wr_s & ~HWDATA[0]);
  assign tick_s     = (presc_cnt_r == presc_act_r);
  assign fall_s     = ~eng_off_s & tick_s & sck_r;
  assign bit_next_s = started_r ? (bit_cnt_r + 6'd1) : 6'd0;
  assign k0_s       = (bit_next_s[4:0] == 5'd0);
  assign k1_s       = fall_s & (bit_next_s[4:0] == 5'd1);

  assign push_s = data_wr_s & ~full_s & ~flush_r;
  assign pop_s  = k1_s & ~empty_s & ~flush_r;

  assign unused_s  = ^{HSIZE, HADDR[31:8], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign SCK       = sck_r;
  assign WS        = ws_r;
  assign SD        = sd_r;
  assign IRQ       = irq_r;

  // Address-phase capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_r  <= 8'hFF;
      write_r <= 1'b0;
      trans_r <= 1'b0;
      sel_r   <= 1'b0;
    end else if (HREADY) begin
      addr_r  <= HADDR[7:0];
      write_r <= HWRITE;
      trans_r <= HTRANS[1];
      sel_r   <= HSEL;
    end
  end

  // Read mux from the latched address
  always_comb begin
    HRDATA = 32'hBADDBEEF;
    case (addr_r)
      8'h00:   HRDATA = {30'd0, irq_en_r, ctrl_en_r};
      8'h04:   HRDATA = 32'd0;
      8'h08:   HRDATA = {17'd0, 7'(level_r), 4'd0, ovf_r, unf_r, full_s, empty_s};
      8'h0C:   HRDATA = {{(32-DIV_W){1'b0}}, presc_r};
      8'h10:   HRDATA = {{(32-LW){1'b0}}, thresh_r};
      default: HRDATA = 32'hBADDBEEF;
    endcase
  end

  // Control/status registers, sticky flags and interrupt
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_en_r <= 1'b0;
      irq_en_r  <= 1'b0;
      flush_r   <= 1'b0;
      presc_r   <= DIV_W'(3);
      thresh_r  <= LW'(FIFO_DEPTH / 2);
      unf_r     <= 1'b0;
      ovf_r     <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      flush_r <= ctrl_wr_s & HWDATA[2];
      if (ctrl_wr_s) begin
        ctrl_en_r <= HWDATA[0];
        irq_en_r  <= HWDATA[1];
      end
      if (wr_s && addr_r == 8'h0C) presc_r <= HWDATA[DIV_W-1:0];
      if (wr_s && addr_r == 8'h10) thresh_r <= HWDATA[LW-1:0];
      unf_r <= (k1_s & empty_s) | (unf_r & ~(stat_wr_s & HWDATA[2]));
      ovf_r <= (data_wr_s & full_s) | (ovf_r & ~(stat_wr_s & HWDATA[3]));
      irq_r <= irq_en_r & ((level_r <= thresh_r) | unf_r);
    end
  end

  // FIFO pointers and level; a pending flush overrides push and pop
  always_ff @(posedge HCLK) begin
    if (HRESET || flush_r) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge HCLK) begin
    if (push_s) mem_r[wr_ptr_r] <= HWDATA;
  end

  // I2S engine: prescaler, SCK, and per-falling-edge WS/SD update
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc_cnt_r <= {DIV_W{1'b0}};
      presc_act_r <= DIV_W'(3);
      sck_r       <= 1'b0;
      ws_r        <= 1'b0;
      sd_r        <= 1'b0;
      bit_cnt_r   <= 6'd0;
      shift_r     <= 32'd0;
      started_r   <= 1'b0;
    end else if (eng_off_s) begin
      presc_cnt_r <= {DIV_W{1'b0}};
      presc_act_r <= presc_r;
      sck_r       <= 1'b0;
      ws_r        <= 1'b0;
      sd_r        <= 1'b0;
      bit_cnt_r   <= 6'd0;
      shift_r     <= 32'd0;
      started_r   <= 1'b0;
    end else if (tick_s) begin
      presc_cnt_r <= {DIV_W{1'b0}};
      presc_act_r <= presc_r;
      sck_r       <= ~sck_r;
      if (sck_r) begin
        started_r <= 1'b1;
        bit_cnt_r <= bit_next_s;
        if (k1_s) begin
          shift_r <= fifo_head_s;
          sd_r    <= fifo_head_s[31];
        end else begin
          // bit 30 of the left-shifted word is next; at k=0 it is the old LSB
          sd_r    <= shift_r[30];
          shift_r <= {shift_r[30:0], 1'b0};
          if (k0_s) ws_r <= bit_next_s[5];
        end
      end
    end else begin
      presc_cnt_r <= presc_cnt_r + DIV_W'(1'b1);
    end
  end

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
// Scoreboard bench for ahbl_i2s_tx: a word-level model predicts the WS/SD
// value at every SCK falling edge; a monitor compares as edges appear.
module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SCK, WS, SD, IRQ;

  int errors = 0;
  int checks = 0;
  logic [1:0]  exp_q [$];
  logic [31:0] mw [$];

  ahbl_i2s_tx #(.FIFO_DEPTH(16), .DIV_W(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HSEL(HSEL),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .SCK(SCK), .WS(WS), .SD(SD), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HADDR = {24'd0, a}; HTRANS = 2'b10; HWRITE = 1'b1; HSEL = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = d; HTRANS = 2'b00; HSEL = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    HADDR = {24'd0, a}; HTRANS = 2'b10; HWRITE = 1'b0; HSEL = 1'b1;
    @(posedge HCLK); #1;
    d = HRDATA; HTRANS = 2'b00; HSEL = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic chk_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    ahb_write(8'h04, w);
    mw.push_back(w);
  endtask

  // Edge n: slot n/32 (WS = slot parity); k=0 carries the previous word's LSB,
  // k=1..31 carry bits 31..1 of the current word; missing words are zero.
  task automatic gen_stream(input int e_cnt);
    for (int n = 0; n < e_cnt; n++) begin
      int slot, k;
      logic [31:0] cur, prv;
      logic b;
      slot = n / 32;
      k    = n % 32;
      cur  = (slot < mw.size()) ? mw[slot] : 32'd0;
      prv  = (slot >= 1 && slot - 1 < mw.size()) ? mw[slot-1] : 32'd0;
      b    = (k == 0) ? prv[0] : cur[32-k];
      exp_q.push_back({slot[0], b});
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(posedge HCLK); n++;
    end
    chk(name, exp_q.size(), 0);
    #1;
  endtask

  task automatic wait_falls(input int target);
    int f = 0;
    logic p;
    p = SCK;
    for (int c = 0; c < 10000 && f < target; c++) begin
      @(negedge HCLK);
      if (p && !SCK) f++;
      p = SCK;
    end
    chk("wait_falls", f, target);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic p;
    logic [1:0] e;
    int idx;
    p = 1'b0; idx = 0;
    forever begin
      @(negedge HCLK);
      if (p && !SCK && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({WS, SD} !== e) begin
          errors++;
          $display("FAIL stream[%0d]: got ws/sd %b expected %b", idx, {WS, SD}, e);
        end
        idx++;
      end
      p = SCK;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, rise_at, fall_at, m;
    logic p;
    HRESET = 1'b1; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'd0; HSEL = 1'b0; HREADY = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hrdata", HRDATA, 32'hBADDBEEF);
    chk("rst_outs", {28'd0, SCK, WS, SD, IRQ}, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    chk_reg("rst_status", 8'h08, 32'h00000001);
    chk_reg("unmapped", 8'h14, 32'hBADDBEEF);
    chk_reg("rst_ctrl", 8'h00, 32'd0);
    chk_reg("rst_presc", 8'h0C, 32'd3);
    chk_reg("rst_thresh", 8'h10, 32'd8);

    // Directed frame with first-edge timing
    ahb_write(8'h0C, 32'd1);
    mw.delete();
    push_word(32'hA5A5A5A5);
    push_word(32'h0F0F0F0F);
    chk_reg("two_words", 8'h08, 32'h00000200);
    gen_stream(96);
    ahb_write(8'h00, 32'd1);
    rise_at = 0; fall_at = 0; p = SCK;
    for (int n = 1; n <= 10; n++) begin
      @(posedge HCLK); #1;
      if (!p && SCK && rise_at == 0) rise_at = n;
      if (p && !SCK && fall_at == 0) fall_at = n;
      p = SCK;
    end
    chk("first_rise", rise_at, 2);
    chk("first_fall", fall_at, 4);
    wait_drain("drain_directed");
    chk_reg("unf_after_directed", 8'h08, 32'h00000005);
    ahb_write(8'h00, 32'd0);
    ahb_write(8'h08, 32'h4);
    chk_reg("unf_cleared", 8'h08, 32'h00000001);

    // Fill, overflow, clear OVF
    mw.delete();
    for (int i = 0; i < 16; i++) push_word($urandom);
    ahb_write(8'h04, $urandom);
    chk_reg("full_ovf", 8'h08, 32'h0000100A);
    ahb_write(8'h08, 32'h8);
    chk_reg("ovf_cleared", 8'h08, 32'h00001002);

    // Threshold IRQ while draining the 16 words
    ahb_write(8'h0C, 32'd0);
    ahb_write(8'h10, 32'd8);
    ahb_write(8'h00, 32'd2);
    @(posedge HCLK); #1;
    chk("irq_above_thresh", {31'd0, IRQ}, 32'd0);
    gen_stream(32 * 16 + 32);
    ahb_write(8'h00, 32'd3);
    f = 0; p = SCK;
    for (int c = 0; c < 4000 && f < 226; c++) begin
      @(negedge HCLK);
      if (p && !SCK) begin
        f++;
        if (f == 226) chk("irq_at_8th_pop", {31'd0, IRQ}, 32'd0);
      end
      p = SCK;
    end
    chk("irq_falls", f, 226);
    @(negedge HCLK);
    chk("irq_rise", {31'd0, IRQ}, 32'd1);
    wait_drain("drain_irq");
    chk_reg("irq_end_status", 8'h08, 32'h00000005);

    // Enable with an empty FIFO
    ahb_write(8'h00, 32'd0);
    ahb_write(8'h08, 32'h4);
    chk_reg("pre_empty_status", 8'h08, 32'h00000001);
    mw.delete();
    gen_stream(64);
    ahb_write(8'h00, 32'd3);
    wait_drain("drain_empty");
    chk_reg("empty_unf", 8'h08, 32'h00000005);
    chk("empty_irq", {31'd0, IRQ}, 32'd1);
    ahb_write(8'h00, 32'd0);
    ahb_write(8'h08, 32'h4);
    chk("irq_off", {31'd0, IRQ}, 32'd0);

    // FLUSH immediately followed by a DATA write: flush wins
    for (int i = 0; i < 4; i++) ahb_write(8'h04, $urandom);
    chk_reg("four_words", 8'h08, 32'h00000400);
    HADDR = 32'h00; HTRANS = 2'b10; HWRITE = 1'b1; HSEL = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'h4; HADDR = 32'h04;
    @(posedge HCLK); #1;
    HWDATA = $urandom; HTRANS = 2'b00; HSEL = 1'b0;
    @(posedge HCLK); #1;
    chk_reg("flush_wins", 8'h08, 32'h00000001);

    // EN cleared mid right slot
    ahb_write(8'h0C, 32'd1);
    for (int i = 0; i < 3; i++) ahb_write(8'h04, $urandom);
    ahb_write(8'h00, 32'd1);
    wait_falls(40);
    chk("mid_ws", {31'd0, WS}, 32'd1);
    ahb_write(8'h00, 32'd0);
    chk("mid_disable", {29'd0, SCK, WS, SD}, 32'd0);
    chk_reg("mid_retained", 8'h08, 32'h00000100);
    ahb_write(8'h00, 32'h4);
    chk_reg("mid_flushed", 8'h08, 32'h00000001);

    // Randomized rounds; each re-enable restarts the frame at WS=0
    for (int r = 0; r < 4; r++) begin
      ahb_write(8'h0C, $urandom_range(0, 3));
      mw.delete();
      m = $urandom_range(1, 16);
      for (int i = 0; i < m; i++) push_word($urandom);
      gen_stream(32 * m + 32);
      ahb_write(8'h00, 32'd1);
      wait_drain("drain_rand");
      chk_reg("rand_status", 8'h08, 32'h00000005);
      ahb_write(8'h00, 32'd0);
      ahb_write(8'h08, 32'h4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_i2s_tx.md
Name: ahbl_i2s_tx

Overview:
AHB-Lite slave I2S transmitter, the playback counterpart of the team's AHB-Lite I2S receiver. Software pushes 32-bit samples into a TX FIFO. The engine acts as I2S bus master: it generates SCK and WS and shifts samples out on SD in Philips I2S format, left slot first. A level-threshold IRQ tells the CPU to refill the FIFO.

Parameters:
FIFO_DEPTH, 16, TX FIFO depth in 32-bit words; power of two, max 64.
DIV_W, 8, width of the SCK prescaler.

Ports:
HCLK  in  1  system clock; the only clock.
HRESET  in  1  reset; synchronous, active-high.
HADDR  in  32  AHB address.
HTRANS  in  2  AHB transfer type.
HWRITE  in  1  AHB write.
HSIZE  in  3  AHB size; ignored, all accesses treated as 32-bit.
HWDATA  in  32  AHB write data.
HSEL  in  1  slave select.
HREADY  in  1  bus ready.
HRDATA  out  32  read data.
HREADYOUT  out  1  tied to 1; zero wait states.
SCK  out  1  I2S bit clock.
WS  out  1  I2S word select; 0 = left, 1 = right.
SD  out  1  I2S serial data.
IRQ  out  1  interrupt, active-high level.

Behaviour:
- Bus interface
  - HADDR, HWRITE, HTRANS and HSEL are latched when HREADY=1.
  - Data phase is active when latched HTRANS[1] & HSEL.
  - Register decode uses latched HADDR[7:0].
  - HRDATA is combinational from the latched address.
  - Unmapped reads return 0xBADDBEEF.
- 0x00 CTRL (reset 0)
  - bit0 EN, bit1 IRQ_EN.
  - bit2 FLUSH: write-1 pulse, reads 0. Empties the FIFO the cycle after the write. On a same-cycle push, flush wins.
- 0x04 DATA (write-only, reads 0)
  - A write pushes HWDATA.
  - Write while full is dropped, sets OVF, FIFO unchanged.
  - A push and a pop in the same cycle leave level unchanged. "Full" is judged before the pop.
- 0x08 STATUS
  - Bit fields: [0] empty, [1] full, [2] UNF sticky, [3] OVF sticky, [14:8] level.
  - Writing 1 to bit2 or bit3 clears that flag. If a set and a clear happen in the same cycle, set wins.
- 0x0C PRESC (reset 3): SCK half-period = PRESC+1 HCLK cycles.
- 0x10 THRESH (reset FIFO_DEPTH/2), width log2(FIFO_DEPTH)+1.
- Engine disabled (EN=0)
  - SCK=0, WS=0, SD=0.
  - Prescaler, bit counter (6-bit, bit_cnt) and shift register are held at 0.
  - The FIFO remains writable.
- Engine enabled (EN=1)
  - The prescaler counts 0..PRESC. At terminal count SCK toggles and the prescaler clears.
  - The first SCK rise is PRESC+1 cycles after EN=1. The first fall is 2*(PRESC+1) cycles after EN=1.
  - A PRESC write while running takes effect at the next prescaler wrap.
- Actions on each SCK falling edge (same HCLK cycle as SCK 1->0); let k = new bit_cnt mod 32:
  - k=0: WS <= new bit_cnt[5]; SD <= bit 0 of the previous word (0 on the first frame after enable).
  - k=1: pop the FIFO into the shift register and drive SD <= bit31. If the FIFO is empty, load 0 and set UNF.
  - k=2..31: SD <= next bit, MSB-first.
  - Result: MSB lags the WS edge by one SCK; 64 SCK per stereo frame.
  - The first falling edge after enable produces bit_cnt=0, so WS=0.
- FIFO words alternate left, right, left, ...
- EN cleared mid-frame: the engine returns to the disabled state on the next cycle, with no frame completion. FIFO contents are retained.
- IRQ
  - IRQ is registered: IRQ <= IRQ_EN & ((level <= THRESH) | UNF).
  - It deasserts one cycle after the condition clears.
- HRESET (any time)
  - Clears the FIFO, flags, CTRL, the engine and IRQ.
  - PRESC returns to 3; THRESH returns to FIFO_DEPTH/2.
  - All outputs return to 0 except HREADYOUT=1 and HRDATA, which is combinational from the latched address and reads 0xBADDBEEF after reset.

Test Plan:
- Reset, read 0x08 -> 0x00000001 (empty, level 0). Read 0x14 -> 0xBADDBEEF. SCK/WS/SD/IRQ = 0.
- PRESC=1, push 0xA5A5A5A5 then 0x0F0F0F0F, EN=1:
  - SCK period is 4 HCLK; first fall occurs 4 cycles after EN.
  - SD = 0 on edge 0, then bits 31..1 of 0xA5A5A5A5 on edges 1..31.
  - Bit0 = 1 at edge 32, where WS rises.
  - Right slot carries 0x0F0F0F0F.
- Push 16 words, then a 17th write -> full=1, OVF=1, level 16. Write 0x8 to STATUS -> OVF=0.
- IRQ_EN=1, THRESH=8, enabled with 16 words -> IRQ rises the cycle after level hits 8 (after the 8th pop).
- Enable with an empty FIFO -> SD stays 0, UNF=1 after the first k=1 edge, IRQ=1 if IRQ_EN.
- Push 4 words, then FLUSH in the same cycle as a DATA write -> level 0, empty=1. Clear EN mid-slot -> SCK/WS/SD = 0 the next cycle. Re-enable -> the frame restarts at WS=0.
